ripple_add_seq: RTL



---
 rtl/ripple_add_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ripple_add_seq.sv
// ripple_add_seq: multi-cycle WIDTH-bit adder built from one SLICE-bit
// ripple-carry slice that is reused over N = WIDTH/SLICE cycles. The carry
// between slices lives in a register.
//
// WIDTH must be an integer multiple of SLICE.
//
// Optional feature, enabled by defining RIPPLE_ADD_SEQ_OVF_EN:
//    adds the output ovf, the signed two's-complement overflow of the sum,
//    valid together with out_valid.
//
// Ports:
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   request carries valid a, b, cin
//    in_ready   out  block can accept a request (IDLE only)
//    a, b       in   WIDTH-bit operands
//    cin        in   carry-in to bit 0
//    out_valid  out  sum/cout valid (DONE)
//    out_ready  in   consumer accepts result
//    sum        out  a + b + cin mod 2^WIDTH
//    cout       out  carry-out of the MSB
//    busy       out  high in RUN or DONE
//    ovf        out  signed overflow (only with RIPPLE_ADD_SEQ_OVF_EN)
module ripple_add_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef RIPPLE_ADD_SEQ_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int N     = WIDTH / SLICE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q,     state_d;
   logic [WIDTH-1:0]   a_q,         a_d;
   logic [WIDTH-1:0]   b_q,         b_d;
   logic [WIDTH-1:0]   sum_q,       sum_d;
   logic [IDX_W-1:0]   idx_q,       idx_d;
   logic               carry_q,     carry_d;
   logic               cout_q,      cout_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q,      busy_d;

   // The single shared ripple slice: operand bits selected by idx_q.
   logic [SLICE-1:0]   a_sl;
   logic [SLICE-1:0]   b_sl;
   logic [SLICE:0]     slice_res;
   logic               last_slice;

   assign a_sl       = a_q[idx_q*SLICE +: SLICE];
   assign b_sl       = b_q[idx_q*SLICE +: SLICE];
   assign slice_res  = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
   assign last_slice = (idx_q == IDX_W'(N - 1));

`ifdef RIPPLE_ADD_SEQ_OVF_EN
   logic ovf_q, ovf_d;
   logic msb_cin;
   // Carry into the MSB recovered from the top bit of the slice: s = a ^ b ^ c.
   assign msb_cin = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_res[SLICE-1];
`endif

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise a latch would be inferred.
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               carry_d    = cin;
               idx_d      = '0;
               sum_d      = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
            carry_d = slice_res[SLICE];
            idx_d   = idx_q + IDX_W'(1);
            if (last_slice) begin
               idx_d       = '0;
               cout_d      = slice_res[SLICE];
               out_valid_d = 1'b1;
               state_d     = DONE;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
               ovf_d       = msb_cin ^ slice_res[SLICE];
`endif
            end
         end
         DONE: begin
            // in_ready only returns after this handshake, so a new request
            // can never overlap the result still being presented.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples
   // the pre-edge values; the operand registers are plain flops and are
   // reset like the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef RIPPLE_ADD_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
